decoder_scan_n: RTL and testbench



---
 rtl/decoder_scan_n_pkg.sv | 26 ++
 rtl/decoder_scan_n_if.sv | 25 ++
 rtl/decoder_scan_n_dwell_timer.sv | 28 ++
 rtl/decoder_scan_n.sv | 84 ++++++++
 tb/tb_decoder_scan_n.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_scan_n_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
// Holds the mode encoding and the one-hot decode function.
package decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    // Widest select the decode helper supports.
    localparam int MAX_N = 8;

    // One-hot decode of sel; bits at or above 2^n stay clear.
    function automatic logic [2**MAX_N-1:0] onehot(
        input logic [MAX_N-1:0] sel,
        input int               n
    );
        logic [2**MAX_N-1:0] v;
        v = '0;
        if (int'(sel) < (1 << n)) begin
            v[sel] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/status bundle of the scanning decoder.
// The master drives the controls; the decoder drives y/sel/wrap.
interface decoder_scan_n_if #(
    parameter int N       = 3,
    parameter int DWELL_W = 8
);
    logic               en;
    logic               mode;
    logic               load;
    logic [N-1:0]       addr;
    logic [DWELL_W-1:0] dwell;
    logic [2**N-1:0]    y;
    logic [N-1:0]       sel;
    logic               wrap;

    modport master (
        output en, mode, load, addr, dwell,
        input  y, sel, wrap
    );

    modport slave (
        input  en, mode, load, addr, dwell,
        output y, sel, wrap
    );
endinterface

// File: rtl/decoder_scan_n_dwell_timer.sv
// Dwell counter for the scan pointer.
// tick fires when the hold time has elapsed while running.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);
    logic [DWELL_W-1:0] cnt;

    // >= so a dwell lowered below cnt still advances at once.
    assign tick = run & (cnt >= dwell);

    // Count up while running; restart on tick or clear; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with enable, direct load and auto-scan.
// y decodes the next-state pointer so sel and y move together.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic              clk,
    input logic              rst,
    decoder_scan_n_if.slave  bus
);
    localparam int W = 2**N;
    localparam logic [W-1:0] IDLE = {W{ACTIVE_LOW}};

    logic [N-1:0] sel_q;
    logic [N-1:0] sel_d;
    logic         wrap_q;
    logic         wrap_d;
    logic [W-1:0] y_q;
    logic [W-1:0] y_d;
    mode_t        mode_q;
    mode_t        mode_in;
    logic         chg;
    logic         clr;
    logic         run;
    logic         tick;

    assign mode_in = mode_t'(bus.mode);
    assign chg     = (mode_in != mode_q);

    // Direct mode, loads and mode switches park the counter at 0.
    assign clr = bus.en & (bus.load | chg | (mode_in == MODE_DIRECT));
    assign run = bus.en & ~bus.load & ~chg & (mode_in == MODE_SCAN);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .run   (run),
        .dwell (bus.dwell),
        .tick  (tick)
    );

    // Next pointer, wrap pulse and decoded output.
    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        y_d    = IDLE;
        if (bus.en) begin
            if (bus.load) begin
                sel_d = bus.addr;
            end else if (tick) begin
                sel_d  = sel_q + 1'b1;
                wrap_d = &sel_q;
            end
            y_d = W'(onehot(MAX_N'(sel_d), N)) ^ IDLE;
        end
    end

    // State and output registers; en=0 freezes mode tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            wrap_q <= 1'b0;
            y_q    <= IDLE;
            mode_q <= MODE_DIRECT;
        end else begin
            sel_q  <= sel_d;
            wrap_q <= wrap_d;
            y_q    <= y_d;
            if (bus.en) begin
                mode_q <= mode_in;
            end
        end
    end

    assign bus.y    = y_q;
    assign bus.sel  = sel_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: directed scenarios plus random traffic
// against a behavioural model, on an N=3 and an N=2 active-low copy.
module tb_decoder_scan_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decoder_scan_n_if #(.N(3), .DWELL_W(8)) ia ();
    decoder_scan_n_if #(.N(2), .DWELL_W(8)) ib ();

    decoder_scan_n #(
        .N          (3),
        .DWELL_W    (8),
        .ACTIVE_LOW (1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    decoder_scan_n #(
        .N          (2),
        .DWELL_W    (8),
        .ACTIVE_LOW (1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic       en_s;
    logic       mode_s;
    logic       load_s;
    logic [2:0] addr_s;
    logic [7:0] dwell_s;

    int m_sel  [2];
    int m_cnt  [2];
    int m_mq   [2];
    int m_wrap [2];
    int m_y    [2];

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference behaviour of one decoder, taken straight from the rules.
    task automatic step(input int k, input int nb, input bit al);
        int size;
        int a;
        int mask;
        size = 1 << nb;
        mask = size - 1;
        a    = int'(addr_s) & mask;
        m_wrap[k] = 0;
        if (rst) begin
            m_sel[k] = 0;
            m_cnt[k] = 0;
            m_mq[k]  = 0;
        end else if (en_s) begin
            if (load_s) begin
                m_sel[k] = a;
                m_cnt[k] = 0;
            end else if (int'(mode_s) != m_mq[k]) begin
                m_cnt[k] = 0;
            end else if (!mode_s) begin
                m_cnt[k] = 0;
            end else if (m_cnt[k] >= int'(dwell_s)) begin
                m_wrap[k] = (m_sel[k] == size - 1) ? 1 : 0;
                m_sel[k]  = (m_sel[k] + 1) % size;
                m_cnt[k]  = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            m_mq[k] = int'(mode_s);
        end
        if (!rst && en_s) m_y[k] = 1 << m_sel[k];
        else m_y[k] = 0;
        if (al) m_y[k] = ~m_y[k] & mask_of(size);
    endtask

    function automatic int mask_of(input int size);
        return (1 << size) - 1;
    endfunction

    // One clock: drive, advance model, compare both copies.
    task automatic cyc();
        ia.en    = en_s;
        ia.mode  = mode_s;
        ia.load  = load_s;
        ia.addr  = addr_s;
        ia.dwell = dwell_s;
        ib.en    = en_s;
        ib.mode  = mode_s;
        ib.load  = load_s;
        ib.addr  = addr_s[1:0];
        ib.dwell = dwell_s;
        @(posedge clk);
        #1;
        step(0, 3, 1'b0);
        step(1, 2, 1'b1);
        chk("a_y",    int'(ia.y),    m_y[0]);
        chk("a_sel",  int'(ia.sel),  m_sel[0]);
        chk("a_wrap", int'(ia.wrap), m_wrap[0]);
        chk("b_y",    int'(ib.y),    m_y[1]);
        chk("b_sel",  int'(ib.sel),  m_sel[1]);
        chk("b_wrap", int'(ib.wrap), m_wrap[1]);
    endtask

    initial begin
        int w1;
        int w2;
        int nw;

        rst     = 1'b1;
        en_s    = 1'b1;
        mode_s  = 1'b0;
        load_s  = 1'b0;
        addr_s  = '0;
        dwell_s = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_y_a",   int'(ia.y),   'h00);
        chk("rst_sel_a", int'(ia.sel), 0);
        chk("rst_y_b",   int'(ib.y),   'hF);

        // Direct load
        load_s = 1'b1;
        addr_s = 3'd5;
        cyc();
        load_s = 1'b0;
        chk("load5_y",   int'(ia.y),   'h20);
        chk("load5_sel", int'(ia.sel), 5);
        chk("load1_y_b", int'(ib.y),   'hD);

        // Full-speed scan
        mode_s  = 1'b1;
        dwell_s = 8'd0;
        load_s  = 1'b1;
        addr_s  = 3'd0;
        cyc();
        load_s = 1'b0;
        chk("scan0_y", int'(ia.y), 'h01);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("scan_y",    int'(ia.y),    1 << (i % 8));
            chk("scan_wrap", int'(ia.wrap), (i == 8) ? 1 : 0);
        end

        // Dwell of 2: 3-cycle hold, 24-cycle wrap period
        dwell_s = 8'd2;
        load_s  = 1'b1;
        cyc();
        load_s = 1'b0;
        w1 = -1;
        w2 = -1;
        nw = 0;
        for (int i = 0; i < 48; i++) begin
            cyc();
            if (i == 1) chk("hold_y1", int'(ia.y), 'h01);
            if (i == 2) chk("hold_y2", int'(ia.y), 'h02);
            if (ia.wrap) begin
                if (nw == 0) w1 = i;
                else w2 = i;
                nw++;
            end
        end
        chk("wrap_first",  w1, 23);
        chk("wrap_second", w2, 47);
        chk("wrap_count",  nw, 2);

        // Lowering dwell below cnt advances on the next edge
        dwell_s = 8'd5;
        load_s  = 1'b1;
        cyc();
        load_s = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("lower_pre", int'(ia.sel), 0);
        dwell_s = 8'd1;
        cyc();
        chk("lower_adv", int'(ia.sel), 1);

        // Enable gating at sel=6
        dwell_s = 8'd3;
        load_s  = 1'b1;
        addr_s  = 3'd6;
        cyc();
        load_s = 1'b0;
        cyc();
        en_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("gate_y",   int'(ia.y),   0);
            chk("gate_sel", int'(ia.sel), 6);
        end
        en_s = 1'b1;
        cyc();
        chk("ungate_y", int'(ia.y), 'h40);
        cyc();
        chk("resume_hold", int'(ia.sel), 6);
        cyc();
        chk("resume_adv", int'(ia.sel), 7);

        // Load colliding with a due advance from sel=7
        dwell_s = 8'd0;
        load_s  = 1'b1;
        addr_s  = 3'd7;
        cyc();
        addr_s = 3'd2;
        cyc();
        load_s = 1'b0;
        chk("coll_sel",  int'(ia.sel),  2);
        chk("coll_wrap", int'(ia.wrap), 0);
        cyc();
        chk("coll_next", int'(ia.sel), 3);

        // Mid-scan reset
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_y_b",   int'(ib.y),   'hF);
        chk("mrst_sel_b", int'(ib.sel), 0);
        chk("mrst_y_a",   int'(ia.y),   0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            en_s   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) mode_s = ~mode_s;
            load_s = ($urandom_range(0, 14) == 0);
            addr_s = 3'($urandom);
            if ($urandom_range(0, 19) == 0) dwell_s = 8'($urandom_range(0, 5));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
